// File: rtl/gold_seq_gen.sv
// Purpose   : Gold-code chip generator, two Fibonacci LFSRs XORed (or either alone / zero).
// Latency   : chip_valid rises one clk after the cycle the divider strobes.
// Backpress.: none; enable low freezes every counter and LFSR, load re-seeds.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   enable          run; low freezes divider, LFSRs and index counter
//   load            one-cycle re-seed strobe (priority over enable)
//   seed_b_in       LFSR B seed used on load (0 falls back to SEED_B)
//   mode            0 A^B, 1 A only, 2 B only, 3 constant 0
//   clk_div         chip period = clk_div+1 clk cycles
//   chip_out        current chip (registered)
//   chip_valid      one-cycle pulse when chip_out updates
//   epoch           pulses with chip_valid on chip index 0
//   chip_idx        index of chip currently on chip_out
module gold_seq_gen #(
   parameter int             N      = 6,
   parameter logic [N-1:0]   POLY_A = 6'b000011,
   parameter logic [N-1:0]   POLY_B = 6'b100111,
   parameter logic [N-1:0]   SEED_A = 6'b000001,
   parameter logic [N-1:0]   SEED_B = 6'b000001,
   parameter int             DIV_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [N-1:0]     seed_b_in,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] clk_div,
   output logic             chip_out,
   output logic             chip_valid,
   output logic             epoch,
   output logic [N-1:0]     chip_idx
);

   // Last index of the period, P-1 = 2^N-2.
   localparam logic [N-1:0] IDX_LAST = {{(N-1){1'b1}}, 1'b0};

   logic [N-1:0]     lfsr_a_q, lfsr_a_d;
   logic [N-1:0]     lfsr_b_q, lfsr_b_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [N-1:0]     idx_q, idx_d;
   logic             chip_out_q, chip_out_d;
   logic             chip_valid_q, chip_valid_d;
   logic             epoch_q, epoch_d;
   logic [N-1:0]     chip_idx_q, chip_idx_d;
   logic             strobe;
   logic             sel_chip;

   // Fibonacci step: new bit enters at the top, output bit is s[0].
   function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s, input logic [N-1:0] taps);
      return {^(s & taps), s[N-1:1]};
   endfunction

   always_comb begin
      // ">=" rather than "==" so a clk_div lowered below the running count
      // still produces a strobe on the next enabled cycle.
      strobe = enable & ~load & (div_cnt_q >= clk_div);

      case (mode)
         2'd0:    sel_chip = lfsr_a_q[0] ^ lfsr_b_q[0];
         2'd1:    sel_chip = lfsr_a_q[0];
         2'd2:    sel_chip = lfsr_b_q[0];
         default: sel_chip = 1'b0;
      endcase

      lfsr_a_d     = lfsr_a_q;
      lfsr_b_d     = lfsr_b_q;
      div_cnt_d    = div_cnt_q;
      idx_d        = idx_q;
      chip_out_d   = chip_out_q;
      chip_valid_d = 1'b0;
      epoch_d      = 1'b0;
      chip_idx_d   = chip_idx_q;

      if (load) begin
         lfsr_a_d  = SEED_A;
         // An all-zero seed would lock LFSR B at zero forever.
         lfsr_b_d  = (seed_b_in == '0) ? SEED_B : seed_b_in;
         div_cnt_d = '0;
         idx_d     = '0;
      end else if (enable) begin
         div_cnt_d = strobe ? '0 : div_cnt_q + DIV_W'(1);
         if (strobe) begin
            chip_out_d   = sel_chip;
            chip_valid_d = 1'b1;
            chip_idx_d   = idx_q;
            epoch_d      = (idx_q == '0);
            // Both registers advance regardless of mode so switching mode
            // never shifts the code phase.
            lfsr_a_d     = lfsr_step(lfsr_a_q, POLY_A);
            lfsr_b_d     = lfsr_step(lfsr_b_q, POLY_B);
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + N'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_a_q     <= SEED_A;
         lfsr_b_q     <= SEED_B;
         div_cnt_q    <= '0;
         idx_q        <= '0;
         chip_out_q   <= 1'b0;
         chip_valid_q <= 1'b0;
         epoch_q      <= 1'b0;
         chip_idx_q   <= '0;
      end else begin
         lfsr_a_q     <= lfsr_a_d;
         lfsr_b_q     <= lfsr_b_d;
         div_cnt_q    <= div_cnt_d;
         idx_q        <= idx_d;
         chip_out_q   <= chip_out_d;
         chip_valid_q <= chip_valid_d;
         epoch_q      <= epoch_d;
         chip_idx_q   <= chip_idx_d;
      end
   end

   assign chip_out   = chip_out_q;
   assign chip_valid = chip_valid_q;
   assign epoch      = epoch_q;
   assign chip_idx   = chip_idx_q;

endmodule

// File: tb/tb_gold_seq_gen.sv
// Purpose   : Directed bench for gold_seq_gen: vector table plus multi-cycle sequences.
// Latency   : outputs checked 1 ns after each rising edge.
// Backpress.: n/a.
module tb_gold_seq_gen;

   localparam int P = 63;

   logic       clk = 1'b0;
   logic       reset, enable, load;
   logic [5:0] seed_b_in;
   logic [1:0] mode;
   logic [7:0] clk_div;
   logic       chip_out, chip_valid, epoch;
   logic [5:0] chip_idx;

   int n_vec = 0;
   int n_err = 0;

   gold_seq_gen #(
      .N(6), .POLY_A(6'b000011), .POLY_B(6'b100111),
      .SEED_A(6'b000001), .SEED_B(6'b000001), .DIV_W(8)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .seed_b_in(seed_b_in), .mode(mode), .clk_div(clk_div),
      .chip_out(chip_out), .chip_valid(chip_valid), .epoch(epoch),
      .chip_idx(chip_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, ld;
      logic [5:0] seed;
      logic [1:0] md;
      logic [7:0] div;
      logic       vld, chip, ep;
      logic [5:0] idx;
   } vec_t;

   vec_t tbl[23];

   logic [P-1:0] sa, sb1, sb2;

   // Reference code sequence: bit k is the LFSR output bit at step k.
   function automatic logic [P-1:0] gen_seq(input logic [5:0] seed, input logic [5:0] taps);
      logic [5:0]   s;
      logic         f;
      logic [P-1:0] r;
      s = seed;
      r = '0;
      for (int k = 0; k < P; k++) begin
         r[k] = s[0];
         f = 1'b0;
         for (int i = 0; i < 6; i++)
            if (taps[i]) f = f ^ s[i];
         s = {f, s[5:1]};
      end
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rst, input logic en, input logic ld,
                        input logic [5:0] seed, input logic [1:0] md, input logic [7:0] div);
      reset = rst; enable = en; load = ld; seed_b_in = seed; mode = md; clk_div = div;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 6'd0, 2'd0, 8'd0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int ones;
      int prev_ep;
      logic [P-1:0] g;

      sa  = gen_seq(6'b000001, 6'b000011);
      sb1 = gen_seq(6'b000001, 6'b100111);
      sb2 = gen_seq(6'b101010, 6'b100111);
      g   = sa ^ sb1;

      //          rst en ld seed   md    div    vld chip ep idx
      tbl[0]  = '{1, 0, 0, 6'd0, 2'd0, 8'd0,  0, 0, 0, 6'd0};
      tbl[1]  = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 1, 1, 6'd0};
      tbl[2]  = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd1};
      tbl[3]  = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd2};
      tbl[4]  = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd3};
      tbl[5]  = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd4};
      tbl[6]  = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd5};
      tbl[7]  = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 1, 0, 6'd6};
      tbl[8]  = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd7};
      // load together with enable: no chip, chip_out/chip_idx hold
      tbl[9]  = '{0, 1, 1, 6'd0, 2'd1, 8'd0,  0, 0, 0, 6'd7};
      tbl[10] = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 1, 1, 6'd0};
      tbl[11] = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd1};
      tbl[12] = '{0, 1, 0, 6'd0, 2'd1, 8'd3,  0, 0, 0, 6'd1};
      // reset mid-divide
      tbl[13] = '{1, 1, 0, 6'd0, 2'd1, 8'd3,  0, 0, 0, 6'd0};
      tbl[14] = '{0, 1, 0, 6'd0, 2'd2, 8'd0,  1, 1, 1, 6'd0};
      tbl[15] = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd1};
      tbl[16] = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd2};
      tbl[17] = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd3};
      tbl[18] = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd4};
      tbl[19] = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd5};
      tbl[20] = '{0, 1, 0, 6'd0, 2'd3, 8'd0,  1, 0, 0, 6'd6};
      tbl[21] = '{0, 1, 0, 6'd0, 2'd1, 8'd0,  1, 0, 0, 6'd7};
      tbl[22] = '{0, 1, 0, 6'd0, 2'd0, 8'd0,  1, 1, 0, 6'd8};

      drive(1'b1, 1'b0, 1'b0, 6'd0, 2'd0, 8'd0);
      tick();

      for (int v = 0; v < 23; v++) begin
         drive(tbl[v].rst, tbl[v].en, tbl[v].ld, tbl[v].seed, tbl[v].md, tbl[v].div);
         tick();
         chk($sformatf("tbl%0d_vld", v),  chip_valid, tbl[v].vld);
         chk($sformatf("tbl%0d_chip", v), chip_out,   tbl[v].chip);
         chk($sformatf("tbl%0d_ep", v),   epoch,      tbl[v].ep);
         chk($sformatf("tbl%0d_idx", v),  chip_idx,   tbl[v].idx);
      end

      // Full period of A alone at clk_div=0, plus the wrap chip.
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 6'd0, 2'd1, 8'd0);
      ones = 0;
      for (int k = 0; k <= P; k++) begin
         tick();
         chk("a_vld",  chip_valid, 1);
         chk("a_idx",  chip_idx,   k % P);
         chk("a_ep",   epoch,      (k % P) == 0);
         chk("a_chip", chip_out,   sa[k % P]);
         if (k < P) ones += chip_out;
      end
      chk("a_ones", ones, 32);

      // Gold at clk_div=3: a chip every 4th cycle, epochs 252 cycles apart.
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 6'd0, 2'd0, 8'd3);
      prev_ep = -1;
      for (int c = 1; c <= P*4+8; c++) begin
         tick();
         chk("g_vld", chip_valid, (c % 4) == 0);
         if ((c % 4) == 0) begin
            int k;
            k = (c / 4 - 1) % P;
            chk("g_chip", chip_out, g[k]);
            chk("g_idx",  chip_idx, k);
            chk("g_ep",   epoch,    k == 0);
            if (k == 0) begin
               if (prev_ep >= 0) chk("g_ep_spacing", c - prev_ep, 252);
               prev_ep = c;
            end
         end else begin
            chk("g_ep_off", epoch, 0);
         end
      end

      // Freeze after chip 20 with clk_div=2, one count already into the next chip.
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 6'd0, 2'd0, 8'd2);
      for (int c = 1; c <= 63; c++) begin
         tick();
         chk("f_vld", chip_valid, (c % 3) == 0);
      end
      chk("f_idx20",  chip_idx, 20);
      chk("f_chip20", chip_out, g[20]);
      tick();
      chk("f_vld_pre", chip_valid, 0);
      enable = 1'b0;
      for (int c = 0; c < 17; c++) begin
         tick();
         chk("f_frz_vld",  chip_valid, 0);
         chk("f_frz_ep",   epoch,      0);
         chk("f_frz_chip", chip_out,   g[20]);
         chk("f_frz_idx",  chip_idx,   20);
      end
      enable = 1'b1;
      tick();
      chk("f_res_vld0", chip_valid, 0);
      tick();
      chk("f_res_vld1", chip_valid, 1);
      chk("f_res_idx",  chip_idx,   21);
      chk("f_res_chip", chip_out,   g[21]);

      // Mid-period load with a custom B seed, then with seed 0.
      tick();
      chk("l_vld_pre", chip_valid, 0);
      drive(1'b0, 1'b1, 1'b1, 6'b101010, 2'd0, 8'd2);
      tick();
      chk("l_ld_vld",  chip_valid, 0);
      chk("l_ld_idx",  chip_idx,   21);
      chk("l_ld_chip", chip_out,   g[21]);
      load = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick(); chk("l1_gap", chip_valid, 0);
         tick(); chk("l1_gap", chip_valid, 0);
         tick();
         chk("l1_vld",  chip_valid, 1);
         chk("l1_idx",  chip_idx,   k);
         chk("l1_ep",   epoch,      k == 0);
         chk("l1_chip", chip_out,   sa[k] ^ sb2[k]);
      end
      drive(1'b0, 1'b1, 1'b1, 6'd0, 2'd0, 8'd2);
      tick();
      chk("l0_ld_vld", chip_valid, 0);
      load = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick(); chk("l0_gap", chip_valid, 0);
         tick(); chk("l0_gap", chip_valid, 0);
         tick();
         chk("l0_vld",  chip_valid, 1);
         chk("l0_idx",  chip_idx,   k);
         chk("l0_ep",   epoch,      k == 0);
         chk("l0_chip", chip_out,   g[k]);
      end

      // clk_div lowered from 200 to 1 while the divider sits at 50.
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 6'd0, 2'd0, 8'd200);
      for (int c = 0; c < 50; c++) begin
         tick();
         chk("d_wait_vld", chip_valid, 0);
      end
      clk_div = 8'd1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("d_vld", chip_valid, (c % 2) == 0);
         if ((c % 2) == 0) begin
            chk("d_idx",  chip_idx, c / 2);
            chk("d_chip", chip_out, g[c / 2]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gold_seq_gen.md
Name: gold_seq_gen

Overview:
- Parametrised Gold-code chip generator built from two Fibonacci LFSRs (preferred pair), XORed to form the output chip.
- Runtime chip-rate divider, runtime code selection via LFSR-B seed, enable/freeze and synchronous re-load.
- Epoch marker and an m-sequence mode for tag ranging/correlation.
- Sits between the tag control logic and the baseband modulator; emits one chip per strobe with a valid pulse.

Parameters:
N, 6, LFSR length; code period P = 2^N-1
POLY_A, 6'b000011, feedback taps of LFSR A (x^6+x+1); bit i = coefficient of x^i, i<N
POLY_B, 6'b100111, feedback taps of LFSR B (x^6+x^5+x^2+x+1)
SEED_A, 6'b000001, LFSR A load value; must be nonzero
SEED_B, 6'b000001, default LFSR B load value; must be nonzero
DIV_W, 8, width of chip-rate divider

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  run; low freezes all state
load  in  1  one-cycle re-seed strobe
seed_b_in  in  N  LFSR B seed applied on load
mode  in  2  0 Gold (A^B), 1 A only, 2 B only, 3 constant 0
clk_div  in  DIV_W  chip period = clk_div+1 clk cycles
chip_out  out  1  current chip (registered)
chip_valid  out  1  one-cycle pulse when chip_out updates
epoch  out  1  pulses with chip_valid on chip index 0 of each period
chip_idx  out  N  index of chip currently on chip_out, 0..P-1

Behaviour:
- LFSR step for state s, taps T: f = XOR-reduce(s & T); s_next = {f, s[N-1:1]}; LFSR output bit = s[0].
- Reset: LFSR A = SEED_A, LFSR B = SEED_B, div_cnt = 0, idx counter = 0, chip_out = 0, chip_valid = 0, epoch = 0, chip_idx = 0.
- Strobe (combinational): strobe = enable & ~load & (div_cnt >= clk_div).
  - ">=" guarantees recovery when clk_div is lowered below div_cnt mid-count: strobe on the next enabled cycle.
- Each enabled non-load cycle: div_cnt <= strobe ? 0 : div_cnt+1.
- On strobe, registered at the same edge:
  - chip_out <= sel(mode, A.s[0], B.s[0]); chip_valid <= 1.
  - chip_idx <= idx counter; epoch <= (idx counter == 0).
  - Both LFSRs step; idx counter <= (idx == P-1) ? 0 : idx+1.
- Off-strobe cycles: chip_valid = 0, epoch = 0; chip_out and chip_idx hold.
- Latency: chip_valid rises one clk after the cycle in which strobe is true. With clk_div=0 and enable held high, chip_valid is high every cycle.
- Chip spacing is exactly clk_div+1 cycles while enable is held high and clk_div is constant.
- enable low: divider, LFSRs and idx counter frozen; chip_out holds; chip_valid and epoch are 0. Resuming continues the sequence with no chip lost or repeated. The partial divider count is preserved.
- load (priority over enable):
  - LFSR A <= SEED_A; LFSR B <= seed_b_in, or SEED_B if seed_b_in == 0 (lock-up guard).
  - div_cnt <= 0; idx counter <= 0; chip_valid = 0.
  - chip_out and chip_idx hold.
  - The next chip emitted is index 0 with epoch = 1.
- mode is sampled at each strobe; a mode change does not reset the sequence position.
- Both LFSRs always step together regardless of mode.
- reset takes priority over load and enable at any time, including mid-period and mid-divide.

Test Plan:
- Reset, mode=1, clk_div=0, enable=1: first 8 chip_out = 1,0,0,0,0,0,1,0. 63 chips contain exactly 32 ones. epoch on chips 0 and 63 only.
- mode=0, clk_div=3, enable=1 for 63*4+8 cycles: chip_valid every 4th cycle. epoch spacing 252 cycles. Sequence matches bit-exact model A^B with seeds 000001/000001. chip_idx runs 0..62 then wraps to 0.
- Freeze test: enable low for 17 cycles mid-period (after chip 20, clk_div=2). No chip_valid during freeze. Next chip is index 21 and equals the model; spacing after resume = remaining divider count.
- load with seed_b_in=6'b101010 mid-period: next chip_valid carries epoch=1, chip_idx=0, and matches model A(SEED_A)^B(101010). load with seed_b_in=0 yields the default SEED_B sequence.
- clk_div lowered from 200 to 1 while div_cnt=50: strobe on the next cycle, then every 2 cycles.
- load and enable high in the same cycle: no chip_valid that cycle. reset asserted mid-chip: all outputs 0 the next cycle, and the sequence restarts from the seeds.
